pipe_wb_stage_multi: RTL and testbench

//  Parametrised MEM/WB pipeline register for the multi-lane core: LANES independent writeback slots.

---
 rtl/pipe_wb_stage_multi.sv | 122 ++++++++++++
 tb/tb_pipe_wb_stage_multi.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_wb_stage_multi.sv
// MEM/WB pipeline register: LANES writeback slots with stall/flush control,
// forwarding lookups off the registered outputs, and a retired-instruction counter.

module pipe_wb_lane #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ZERO_GUARD = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_valid,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);
  logic w_wr;
  assign w_wr = i_write & i_valid & ~((ZERO_GUARD != 0) && (i_addr == '0));

  always_ff @(posedge clock) begin
    if (reset || (!i_hold && i_bubble)) begin
      o_valid <= 1'b0;
      o_write <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
    end else if (!i_hold) begin
      o_valid <= i_valid;
      o_write <= w_wr;
      o_addr  <= i_addr;
      o_data  <= i_data;
    end
  end
endmodule

module pipe_wb_stage_multi #(
  parameter int LANES      = 2,
  parameter int NUM_RD     = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 64,
  parameter int STALL_SRC  = 4,
  parameter int STALL_DST  = 5,
  parameter int ZERO_GUARD = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [5:0]               stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         valid_i,
  input  logic [LANES-1:0]         write_i,
  input  logic [LANES*ADDR_W-1:0]  regw_addr_i,
  input  logic [LANES*DATA_W-1:0]  regw_data_i,
  output logic [LANES-1:0]         valid_o,
  output logic [LANES-1:0]         write_o,
  output logic [LANES*ADDR_W-1:0]  regw_addr_o,
  output logic [LANES*DATA_W-1:0]  regw_data_o,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]         retired_o
);
  logic             w_hold, w_bubble, w_load;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] r_retired;
  logic             w_unused_stall;

  // Downstream stall dominates: a held stage must not be flushed.
  assign w_hold         = stall[STALL_DST];
  assign w_bubble       = flush | stall[STALL_SRC];
  assign w_load         = !w_hold && !w_bubble;
  assign w_unused_stall = ^stall;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pipe_wb_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_GUARD(ZERO_GUARD)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .i_hold  (w_hold),
      .i_bubble(w_bubble),
      .i_valid (valid_i[l]),
      .i_write (write_i[l]),
      .i_addr  (regw_addr_i[l*ADDR_W +: ADDR_W]),
      .i_data  (regw_data_i[l*DATA_W +: DATA_W]),
      .o_valid (valid_o[l]),
      .o_write (write_o[l]),
      .o_addr  (regw_addr_o[l*ADDR_W +: ADDR_W]),
      .o_data  (regw_data_o[l*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) w_pop = w_pop + CNT_W'(valid_i[l]);
  end

  always_ff @(posedge clock) begin
    if (reset)       r_retired <= '0;
    else if (w_load) r_retired <= r_retired + w_pop;
  end
  assign retired_o = r_retired;

  // Ascending lane scan so the youngest matching lane overwrites older ones.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_o[l] && (rd_addr[r*ADDR_W +: ADDR_W] != '0) &&
            (regw_addr_o[l*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])) begin
          fwd_hit[r]                  = 1'b1;
          fwd_data[r*DATA_W +: DATA_W] = regw_data_o[l*DATA_W +: DATA_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_wb_stage_multi.sv
// Directed bench for pipe_wb_stage_multi; a second CNT_W=4 instance covers counter wrap.

module tb_pipe_wb_stage_multi;
  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic [1:0]  valid_i, write_i;
  logic [9:0]  regw_addr_i;
  logic [63:0] regw_data_i;
  logic [9:0]  rd_addr;
  logic [1:0]  valid_o, write_o, fwd_hit;
  logic [9:0]  regw_addr_o;
  logic [63:0] regw_data_o, fwd_data;
  logic [63:0] retired_o;
  logic [1:0]  s_valid_o, s_write_o, s_fwd_hit;
  logic [9:0]  s_regw_addr_o;
  logic [63:0] s_regw_data_o, s_fwd_data;
  logic [3:0]  s_retired_o;

  int errs = 0;
  int chks = 0;

  always #5 clock = ~clock;

  pipe_wb_stage_multi u_dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_i(valid_i), .write_i(write_i), .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
    .valid_o(valid_o), .write_o(write_o), .regw_addr_o(regw_addr_o), .regw_data_o(regw_data_o),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retired_o(retired_o)
  );

  pipe_wb_stage_multi #(.CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_i(valid_i), .write_i(write_i), .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
    .valid_o(s_valid_o), .write_o(s_write_o), .regw_addr_o(s_regw_addr_o), .regw_data_o(s_regw_data_o),
    .rd_addr(rd_addr), .fwd_hit(s_fwd_hit), .fwd_data(s_fwd_data), .retired_o(s_retired_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [4:0] a1, input logic [4:0] a0,
                       input logic [31:0] d1, input logic [31:0] d0);
    valid_i     = v;
    write_i     = w;
    regw_addr_i = {a1, a0};
    regw_data_i = {d1, d0};
  endtask

  initial begin
    reset = 1'b0; stall = '0; flush = 1'b0; rd_addr = '0;
    drive(2'b11, 2'b11, 5'd9, 5'd8, 32'h99, 32'h88);

    // 1: reset wins even with inputs present and stall asserted
    reset = 1'b1; stall = 6'b010000;
    step();
    reset = 1'b0;
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_write", 64'(write_o), 64'h0);
    chk("rst_addr",  64'(regw_addr_o), 64'h0);
    chk("rst_data",  regw_data_o, 64'h0);
    chk("rst_ret",   retired_o, 64'h0);

    // 2: plain load of two lanes
    stall = '0;
    drive(2'b11, 2'b11, 5'd7, 5'd3, 32'hBB, 32'hAA);
    rd_addr = {5'd3, 5'd7};
    step();
    chk("ld_write", 64'(write_o), 64'h3);
    chk("ld_valid", 64'(valid_o), 64'h3);
    chk("ld_addr",  64'(regw_addr_o), {54'h0, 5'd7, 5'd3});
    chk("ld_ret",   retired_o, 64'd2);
    chk("ld_hit",   64'(fwd_hit), 64'h3);
    chk("ld_fwd0",  64'(fwd_data[31:0]), 64'hBB);
    chk("ld_fwd1",  64'(fwd_data[63:32]), 64'hAA);

    // 3: downstream stall holds through flush, then upstream stall bubbles
    stall = 6'b100000; flush = 1'b1;
    drive(2'b11, 2'b11, 5'd9, 5'd8, 32'hCC, 32'hDD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_write", 64'(write_o), 64'h3);
      chk("hold_data",  regw_data_o, {32'hBB, 32'hAA});
      chk("hold_ret",   retired_o, 64'd2);
    end
    stall = 6'b010000; flush = 1'b0;
    step();
    chk("bub_valid", 64'(valid_o), 64'h0);
    chk("bub_write", 64'(write_o), 64'h0);
    chk("bub_data",  regw_data_o, 64'h0);
    chk("bub_ret",   retired_o, 64'd2);
    chk("bub_hit",   64'(fwd_hit), 64'h0);
    chk("bub_fwd",   fwd_data, 64'h0);

    // flush alone bubbles as well
    stall = '0; flush = 1'b1;
    drive(2'b11, 2'b11, 5'd7, 5'd3, 32'hBB, 32'hAA);
    step();
    chk("fl_valid", 64'(valid_o), 64'h0);
    chk("fl_ret",   retired_o, 64'd2);
    flush = 1'b0;

    // 4: same address from both lanes, youngest data forwarded
    drive(2'b11, 2'b11, 5'd5, 5'd5, 32'h22, 32'h11);
    rd_addr = {5'd5, 5'd5};
    step();
    chk("same_write", 64'(write_o), 64'h3);
    chk("same_hit",   64'(fwd_hit), 64'h3);
    chk("same_fwd",   64'(fwd_data[31:0]), 64'h22);
    chk("same_ret",   retired_o, 64'd4);

    // zero-address guard; rd_addr 0 never hits
    drive(2'b11, 2'b11, 5'd0, 5'd5, 32'h44, 32'h33);
    rd_addr = {5'd5, 5'd0};
    step();
    chk("zg_write", 64'(write_o), 64'h1);
    chk("zg_addr",  64'(regw_addr_o), {54'h0, 5'd0, 5'd5});
    chk("zg_hit",   64'(fwd_hit), 64'h2);
    chk("zg_fwd",   fwd_data, {32'h33, 32'h0});
    chk("zg_ret",   retired_o, 64'd6);

    // write without valid is dropped but the valid lane still counts
    drive(2'b10, 2'b11, 5'd6, 5'd4, 32'h66, 32'h55);
    step();
    chk("wv_write", 64'(write_o), 64'h2);
    chk("wv_valid", 64'(valid_o), 64'h2);
    chk("wv_ret",   retired_o, 64'd7);

    // 5: 4-bit counter wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wr_rst", 64'(s_retired_o), 64'h0);
    drive(2'b01, 2'b01, 5'd0, 5'd2, 32'h0, 32'h1);
    for (int i = 0; i < 15; i++) step();
    chk("wr_15",  64'(s_retired_o), 64'd15);
    drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h2, 32'h1);
    step();
    chk("wr_wrap", 64'(s_retired_o), 64'd1);
    chk("wr_wide", retired_o, 64'd17);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
